masked_dot_acc: RTL and testbench

- Evaluator-side linear stage directly upstream of the masked 64-bit ReLU.
- Streams N pairs of (plaintext weight, masked activation) and computes bias + sum(w_i * a_i) mod 2^64.
- The result is the masked pre-activation, presented with a valid/ready handshake. It drives the ReLU's e_input.

---
 rtl/masked_nn_pkg.sv | 15 +
 rtl/masked_mac_pipe.sv | 43 ++++
 rtl/masked_dot_acc.sv | 119 +++++++++++
 tb/tb_masked_dot_acc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/masked_nn_pkg.sv
// Shared types and widths for the masked inference datapath.
// Used by the dot-product accumulator and the ReLU stage.
package masked_nn_pkg;

  localparam int WORD_W = 64;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    OUT
  } dacc_state_t;

endpackage

// File: rtl/masked_mac_pipe.sv
// Two-stage multiply/accumulate: register the product, then add it.
// All arithmetic wraps mod 2^W.
import masked_nn_pkg::*;

module masked_mac_pipe #(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic [W-1:0] i_init,
  input  logic         i_en,
  input  logic [W-1:0] i_w,
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] r_acc;
  logic [W-1:0] r_prod_q;
  logic         r_prod_v;
  logic [W-1:0] w_prod;

  assign w_prod = i_w * i_a;
  assign o_acc  = r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
    end else begin
      if (i_en) r_prod_q <= w_prod;
      if (i_clear) begin
        r_acc    <= i_init;
        r_prod_v <= 1'b0;
      end else begin
        r_prod_v <= i_en;
        if (r_prod_v) r_acc <= r_acc + r_prod_q;
      end
    end
  end

endmodule

// File: rtl/masked_dot_acc.sv
// Masked pre-activation: bias + sum(w_i * a_i) mod 2^WIDTH.
// Result is registered and offered on a valid/ready handshake.
import masked_nn_pkg::*;

module masked_dot_acc #(
  parameter int WIDTH = WORD_W,
  parameter int LEN_W = masked_nn_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_weight,
  input  logic [WIDTH-1:0] in_act,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  dacc_state_t      r_state;
  dacc_state_t      w_next;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             w_clear;
  logic             w_en;
  logic             w_ready;
  logic             w_last;
  logic [WIDTH-1:0] w_acc;

  assign w_last    = (r_cnt == r_len_q - LEN_W'(1));
  assign in_ready  = w_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_en    = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = (cfg_len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        w_ready = 1'b1;
        w_en    = in_valid;
        if (in_valid && w_last) w_next = DRAIN;
      end
      DRAIN: w_next = OUT;
      OUT: begin
        if (r_out_valid && out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The result is captured one cycle after entering OUT so the final
  // pipelined add has landed in the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_q     <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len_q <= cfg_len;
            r_cnt   <= '0;
            if (cfg_len == '0) begin
              r_out_data  <= cfg_bias;
              r_out_valid <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid) r_cnt <= r_cnt + LEN_W'(1);
        end
        OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  masked_mac_pipe #(.W(WIDTH)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_init  (cfg_bias),
    .i_en    (w_en),
    .i_w     (in_weight),
    .i_a     (in_act),
    .o_acc   (w_acc)
  );

endmodule

// File: tb/tb_masked_dot_acc.sv
// Directed and random jobs against a plain-arithmetic dot-product model.
module tb_masked_dot_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [63:0] cfg_bias;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_weight;
  logic [63:0] in_act;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int nchk  = 0;
  int nfail = 0;

  logic [63:0] tw[16];
  logic [63:0] ta[16];

  always #5 clk = ~clk;

  masked_dot_acc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_bias  (cfg_bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_weight (in_weight),
    .in_act    (in_act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] ref_dot(logic [63:0] b, int n);
    logic [63:0] s;
    logic [63:0] p;
    s = b;
    for (int i = 0; i < n; i++) begin
      p = tw[i] * ta[i];
      s = s + p;
    end
    return s;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(string tag, logic [63:0] bias, int n,
                         bit gaps, int hold, bit poke);
    logic [63:0] exp;
    int i;
    int cyc;
    exp = ref_dot(bias, n);
    i = 0;
    cyc = 0;
    start = 1'b1;
    cfg_len = 16'(n);
    cfg_bias = bias;
    tick();
    start = 1'b0;
    cfg_len = 16'($urandom);
    cfg_bias = rnd64();
    if (n == 0) begin
      chk({tag, "_zl_inrdy"}, 64'(in_ready), 64'd0);
    end else begin
      while (i < n && cyc < 200) begin
        chk({tag, "_inrdy_acc"}, 64'(in_ready), 64'd1);
        in_valid = !gaps || (cyc % 2 == 0);
        in_weight = in_valid ? tw[i] : rnd64();
        in_act = in_valid ? ta[i] : rnd64();
        if (poke && cyc == 1) begin
          start = 1'b1;
          cfg_len = 16'd7;
          cfg_bias = rnd64();
        end else begin
          start = 1'b0;
        end
        tick();
        if (in_valid) i++;
        cyc++;
      end
      start = 1'b0;
      chk({tag, "_accepted"}, 64'(i), 64'(n));
      in_valid = 1'b1;
      in_weight = rnd64();
      in_act = rnd64();
      chk({tag, "_inrdy_drop"}, 64'(in_ready), 64'd0);
      chk({tag, "_ov_t0"}, 64'(out_valid), 64'd0);
      tick();
      chk({tag, "_ov_t1"}, 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      tick();
    end
    chk({tag, "_ov"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        start = 1'b1;
        cfg_len = 16'd3;
        cfg_bias = rnd64();
      end
      tick();
      start = 1'b0;
      chk({tag, "_hold_ov"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_busy"}, 64'(busy), 64'd1);
      chk({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_done_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_len = '0;
    cfg_bias = '0;
    in_valid = 1'b0;
    in_weight = '0;
    in_act = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_inrdy", 64'(in_ready), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    tw[0] = 64'd2; ta[0] = 64'd3;
    tw[1] = 64'd4; ta[1] = '1;
    tw[2] = 64'd1; ta[2] = 64'd10;
    run_job("basic", 64'd5, 3, 1'b0, 0, 1'b0);
    chk("basic_model", ref_dot(64'd5, 3), 64'd17);

    tw[0] = 64'h8000_0000_0000_0000; ta[0] = 64'd2;
    tw[1] = '1;                       ta[1] = '1;
    run_job("wrap", 64'd1, 2, 1'b0, 0, 1'b0);

    run_job("zero", 64'hDEAD, 0, 1'b0, 2, 1'b0);

    for (int k = 0; k < 4; k++) begin
      tw[k] = 64'd1;
      ta[k] = 64'd1;
    end
    run_job("stall", 64'd0, 4, 1'b1, 5, 1'b0);

    for (int k = 0; k < 5; k++) begin
      tw[k] = rnd64();
      ta[k] = rnd64();
    end
    run_job("poke", rnd64(), 5, 1'b1, 3, 1'b1);

    start = 1'b1;
    cfg_len = 16'd5;
    cfg_bias = rnd64();
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_weight = rnd64();
    in_act = rnd64();
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_inrdy", 64'(in_ready), 64'd0);
    chk("mid_rst_ov", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    tw[0] = 64'd7; ta[0] = 64'd6;
    run_job("after_rst", 64'd0, 1, 1'b0, 0, 1'b0);

    rst = 1'b1;
    start = 1'b1;
    cfg_len = 16'd0;
    cfg_bias = 64'h55;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_busy", 64'(busy), 64'd0);
    chk("rst_start_ov", 64'(out_valid), 64'd0);

    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        tw[k] = rnd64();
        ta[k] = rnd64();
      end
      run_job("rand", rnd64(), n, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
